// File: rtl/ifetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response
// channel and the instruction stream towards decode.
// master = the fetch unit, slave = its environment (pc_control, imem, decode).
interface ifetch_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_data;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  redirect_valid,
        input  redirect_target,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        output redirect_valid,
        output redirect_target,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit.
// Issues word-aligned fetches from fpc, pairs in-order memory responses with
// rpc and queues {pc, instr} for decode. Requests are credit limited so the
// queue can never overflow: a request is only issued while
// count + (inflight - drop) < FQ_DEPTH. A redirect flushes the queue and marks
// every outstanding request (including one answered in the redirect cycle) as
// to-be-dropped, so no stale instruction ever reaches decode.
module ifetch #(
    parameter int              XLEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    // Every redirect may open up to FQ_DEPTH further outstanding requests
    // while older ones are still waiting to be dropped; the extra bits give
    // headroom for a memory holding many generations of them.
    localparam int IW = CW + 4;

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [IW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] fifo_pc_q    [FQ_DEPTH];
    logic [31:0]     fifo_instr_q [FQ_DEPTH];

    logic [IW:0]     occupancy;
    logic            credit_ok;
    logic            head_valid;
    logic            req_valid;
    logic            accept;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc;
    logic            unused_target_lsb;

    // Credit check and handshake qualifiers, all from registered state plus
    // the redirect flush.
    always_comb begin
        occupancy   = (IW+1)'(count_q) + {1'b0, inflight_q} - {1'b0, drop_q};
        credit_ok   = occupancy < (IW+1)'(FQ_DEPTH);
        head_valid  = (count_q != '0);
        req_valid   = !rst && !bus.redirect_valid && credit_ok;
        accept      = req_valid && bus.imem_req_ready;
        rsp_drop    = bus.imem_rsp_valid && (drop_q != '0);
        push        = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
        pop         = head_valid && bus.instr_ready && !bus.redirect_valid;
        redirect_pc = {bus.redirect_target[XLEN-1:2], 2'b00};
    end

    assign unused_target_lsb = ^bus.redirect_target[1:0];

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fpc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr_data     = fifo_instr_q[rd_ptr_q];
    assign bus.instr_pc       = fifo_pc_q[rd_ptr_q];

    // Next-state: PCs, queue pointers, and the inflight/drop bookkeeping.
    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + IW'(accept) - IW'(bus.imem_rsp_valid);

        if (bus.redirect_valid) begin
            // inflight_d already counts the response landing this cycle,
            // which is discarded along with everything else outstanding.
            fpc_d    = redirect_pc;
            rpc_d    = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = inflight_d;
        end else begin
            if (accept) begin
                fpc_d = fpc_q + PC_STEP;
            end
            if (push) begin
                rpc_d    = rpc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            drop_d  = drop_q - IW'(rsp_drop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q      <= RESET_PC_ALIGNED;
            rpc_q      <= RESET_PC_ALIGNED;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_pc_q[wr_ptr_q]    <= rpc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

    // Invariants the credit scheme and the memory contract guarantee.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_push_full : assert (!(push && (count_q == CW'(FQ_DEPTH))));
            a_drop_le_infl : assert (drop_q <= inflight_q);
            a_rsp_has_req  : assert (!(bus.imem_rsp_valid && (inflight_q == '0)));
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch (XLEN=32, FQ_DEPTH=4, RESET_PC=0) with an
// in-order memory model that answers one cycle after acceptance unless held.
module tb_ifetch;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic rst;
    logic mem_hold;

    always #5 clk = ~clk;

    ifetch_if #(.XLEN(32)) bus ();

    ifetch #(
        .XLEN    (32),
        .FQ_DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] pend     [$];
    logic [31:0] acc_log  [$];
    logic [31:0] pop_pc   [$];
    logic [31:0] pop_data [$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (!rst && !mem_hold && pend.size() != 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_at(pend[0]);
        end
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid && !rst) begin
            pop_pc.push_back(bus.instr_pc);
            pop_data.push_back(bus.instr_data);
        end
        @(posedge clk);
        if (rst) begin
            pend.delete();
        end else begin
            if (bus.imem_rsp_valid) void'(pend.pop_front());
            if (acc) begin
                pend.push_back(a);
                acc_log.push_back(a);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        mem_hold            = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.instr_ready     = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        #1;
        chk("rst_req_valid",   bus.imem_req_valid, 32'd0);
        chk("rst_instr_valid", bus.instr_valid,    32'd0);

        // Reset release with a 1-cycle memory.
        rst = 1'b0;
        acc_log.delete();
        #1;
        chk("rel_req_valid", bus.imem_req_valid, 32'd1);
        chk("rel_req_addr",  bus.imem_req_addr,  32'h0);
        cyc();
        chk("s1_no_instr_yet", bus.instr_valid, 32'd0);
        cyc();
        chk("s1_instr_valid", bus.instr_valid, 32'd1);
        chk("s1_instr_pc0",   bus.instr_pc,    32'h0);
        chk("s1_instr_data0", bus.instr_data,  word_at(32'h0));
        cyc();
        chk("s1_instr_pc4", bus.instr_pc, 32'h4);
        chk("s1_acc_count", acc_log.size(), 32'd3);
        chk("s1_acc0", acc_log[0], 32'h0);
        chk("s1_acc1", acc_log[1], 32'h4);
        chk("s1_acc2", acc_log[2], 32'h8);

        // Decode stalled: credit caps requests at FQ_DEPTH.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        acc_log.delete();
        repeat (10) cyc();
        chk("s2_acc_count", acc_log.size(), 32'd4);
        chk("s2_acc3", acc_log[3], 32'hC);
        #1;
        chk("s2_req_blocked", bus.imem_req_valid, 32'd0);
        chk("s2_head_pc",     bus.instr_pc,       32'h0);
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        repeat (6) cyc();
        chk("s2_acc_after_pop", acc_log.size(), 32'd5);
        chk("s2_acc4", acc_log[4], 32'h10);
        chk("s2_head_pc_after_pop", bus.instr_pc, 32'h4);
        chk("s2_req_blocked_again", bus.imem_req_valid, 32'd0);

        // Redirect to 0x100 with two requests in flight.
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        cyc();
        rst = 1'b0;
        mem_hold = 1'b1;
        acc_log.delete();
        cyc();
        cyc();
        bus.imem_req_ready = 1'b0;
        chk("s3_inflight_acc", acc_log.size(), 32'd2);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        #1;
        chk("s3_redirect_blocks_req", bus.imem_req_valid, 32'd0);
        cyc();
        chk("s3_drop_two", u_dut.drop_q, 32'd2);
        bus.redirect_valid = 1'b0;
        mem_hold           = 1'b0;
        bus.imem_req_ready = 1'b1;
        pop_pc.delete();
        pop_data.delete();
        #1;
        chk("s3_req_valid", bus.imem_req_valid, 32'd1);
        chk("s3_req_addr",  bus.imem_req_addr,  32'h100);
        repeat (6) cyc();
        chk("s3_pop_count", pop_pc.size(), 32'd3);
        chk("s3_pop0_pc",   pop_pc[0],     32'h100);
        chk("s3_pop1_pc",   pop_pc[1],     32'h104);
        chk("s3_pop2_pc",   pop_pc[2],     32'h108);
        chk("s3_pop0_data", pop_data[0],   word_at(32'h100));
        chk("s3_drop_done", u_dut.drop_q,  32'd0);

        // Unaligned redirect target.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h203;
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("s4_req_valid", bus.imem_req_valid, 32'd1);
        chk("s4_req_addr",  bus.imem_req_addr,  32'h200);
        pop_pc.delete();
        repeat (3) cyc();
        chk("s4_pop_count", pop_pc.size(), 32'd1);
        chk("s4_pop0_pc",   pop_pc[0],     32'h200);

        // Redirect coinciding with a response and a pop.
        #1;
        chk("s5_pre_instr_valid", bus.instr_valid, 32'd1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h300;
        pop_pc.delete();
        cyc();
        bus.redirect_valid = 1'b0;
        chk("s5_flushed",     bus.instr_valid,     32'd0);
        chk("s5_no_pop",      pop_pc.size(),       32'd0);
        chk("s5_inflight",    u_dut.inflight_q,    32'd0);
        chk("s5_drop",        u_dut.drop_q,        32'd0);
        #1;
        chk("s5_req_addr", bus.imem_req_addr, 32'h300);
        cyc();
        cyc();
        chk("s5_instr_pc",   bus.instr_pc,   32'h300);
        chk("s5_instr_data", bus.instr_data, word_at(32'h300));

        // Memory stalls for 5 cycles right before the PC wraps.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFE;
        bus.imem_req_ready  = 1'b0;
        cyc();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("s6_hold_valid%0d", i), bus.imem_req_valid, 32'd1);
            chk($sformatf("s6_hold_addr%0d", i),  bus.imem_req_addr,  32'hFFFF_FFFC);
            cyc();
        end
        bus.imem_req_ready = 1'b1;
        #1;
        chk("s6_addr_before_accept", bus.imem_req_addr, 32'hFFFF_FFFC);
        cyc();
        #1;
        chk("s6_addr_wrapped", bus.imem_req_addr, 32'h0);
        cyc();
        chk("s6_instr_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
        cyc();
        chk("s6_instr_pc_wrap",   bus.instr_pc,   32'h0);
        chk("s6_instr_data_wrap", bus.instr_data, word_at(32'h0));

        // Reset in the middle of traffic.
        rst = 1'b1;
        cyc();
        #1;
        chk("s7_rst_instr_valid", bus.instr_valid,    32'd0);
        chk("s7_rst_req_valid",   bus.imem_req_valid, 32'd0);
        rst = 1'b0;
        #1;
        chk("s7_rel_req_valid", bus.imem_req_valid, 32'd1);
        chk("s7_rel_req_addr",  bus.imem_req_addr,  32'h0);
        cyc();
        cyc();
        chk("s7_instr_pc", bus.instr_pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
